// File: rtl/rv64_exec_pkg.sv
// Shared types and constants for the RV64 execute-stage datapath.
package rv64_exec_pkg;

   localparam int XLEN   = 64;
   localparam int NREGS  = 32;
   localparam int REG_AW = $clog2(NREGS);

   localparam logic [1:0] ALUOP_ADD  = 2'b01;
   localparam logic [1:0] ALUOP_SLTU = 2'b10;

   typedef logic [XLEN-1:0]   xlen_t;
   typedef logic [REG_AW-1:0] regaddr_t;

endpackage

// File: rtl/rv64_alu_unit.sv
// Combinational two-operation ALU: ADD (address generation) and unsigned set-less-than.
module rv64_alu_unit
   import rv64_exec_pkg::*;
(
   input  logic [1:0] aluop,
   input  xlen_t      src1,
   input  xlen_t      src2,
   output xlen_t      result
);

   always_comb begin
      // NOTE: default first so every path assigns result and no latch is inferred.
      result = '0;
      case (aluop)
         ALUOP_ADD:  result = src1 + src2;
         ALUOP_SLTU: result = {{(XLEN-1){1'b0}}, (src1 < src2)};
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/rv64_alu_rf.sv
// Execute-stage datapath: 32x64 register file (2R/1W, x0 hardwired) plus ALU.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to the read ports.
module rv64_alu_rf
   import rv64_exec_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] aluop,
   input  xlen_t      src1,
   input  xlen_t      src2,
   output xlen_t      result,
   input  regaddr_t   raddr1,
   output xlen_t      rdata1,
   input  regaddr_t   raddr2,
   output xlen_t      rdata2,
   input  logic       we,
   input  regaddr_t   waddr,
   input  xlen_t      wdata
);

   xlen_t regs_q [NREGS];
   logic  wr_en;

   assign wr_en = we && (waddr != '0);

   // Entry 0 is cleared and never written; reads of address 0 are forced to 0 anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the architectural reset clears every register, so the array is reset in a loop.
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         // NOTE: non-blocking so reads in this cycle still see the old contents.
         regs_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
      rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
`ifdef RF_BYPASS_EN
      if (!rst && wr_en && (raddr1 == waddr)) rdata1 = wdata;
      if (!rst && wr_en && (raddr2 == waddr)) rdata2 = wdata;
`endif
   end

   rv64_alu_unit u_alu (
      .aluop  (aluop),
      .src1   (src1),
      .src2   (src2),
      .result (result)
   );

endmodule

// File: tb/tb_rv64_alu_rf.sv
// Self-checking bench for rv64_alu_rf: directed vectors plus randomized traffic against a reference model.
module tb_rv64_alu_rf;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  aluop;
   logic [63:0] src1, src2, result;
   logic [4:0]  raddr1, raddr2, waddr;
   logic [63:0] rdata1, rdata2, wdata;
   logic        we;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] model_regs [32];

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } alu_vec_t;

   alu_vec_t vecs [10];

   always #5 clk = ~clk;

   rv64_alu_rf dut (
      .clk    (clk),
      .rst    (rst),
      .aluop  (aluop),
      .src1   (src1),
      .src2   (src2),
      .result (result),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .raddr2 (raddr2),
      .rdata2 (rdata2),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] alu_model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      if (op == 2'd1) return a + b;
      if (op == 2'd2) return (a < b) ? 64'd1 : 64'd0;
      return 64'd0;
   endfunction

   // Expected read data given the current (pre-edge) inputs.
   function automatic logic [63:0] read_model(input logic [4:0] ra);
`ifdef RF_BYPASS_EN
      if (!rst && we && waddr != 0 && ra == waddr) return wdata;
`endif
      return (ra == 0) ? 64'd0 : model_regs[ra];
   endfunction

   initial begin
      vecs[0] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1};
      vecs[1] = '{2'b01, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h7FFF_FFFC};
      vecs[2] = '{2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000};
      vecs[3] = '{2'b10, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
      vecs[4] = '{2'b10, 64'h7, 64'h7, 64'h0};
      vecs[5] = '{2'b10, 64'h0, 64'h1, 64'h1};
      vecs[6] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
      vecs[7] = '{2'b00, 64'h1234, 64'h5678, 64'h0};
      vecs[8] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0};
      vecs[9] = '{2'b11, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};

      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      raddr1 = '0; raddr2 = '0; aluop = '0; src1 = '0; src2 = '0;
      #1;
      step();
      rst = 1'b0;

      // Reset state on every address, both ports.
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(31 - i);
         #1;
         check($sformatf("reset_rd1[%0d]", i), rdata1, 64'd0);
         check($sformatf("reset_rd2[%0d]", 31 - i), rdata2, 64'd0);
      end

      // Basic write then read.
      we = 1'b1; waddr = 5'd5; wdata = 64'h1234_5678_8765_4321;
      step();
      we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
      #1;
      check("write_x5_rd1", rdata1, 64'h1234_5678_8765_4321);
      check("write_x5_rd2_same_addr", rdata2, 64'h1234_5678_8765_4321);

      // x0 ignores writes.
      we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      we = 1'b0; raddr2 = 5'd0;
      #1;
      check("write_x0_rd2", rdata2, 64'd0);
      check("x5_untouched", rdata1, 64'h1234_5678_8765_4321);

      // ALU vectors.
      for (int i = 0; i < 10; i++) begin
         aluop = vecs[i].op; src1 = vecs[i].a; src2 = vecs[i].b;
         #1;
         check($sformatf("alu_vec[%0d]", i), result, vecs[i].exp);
      end

      // Read-during-write on x7.
      we = 1'b1; waddr = 5'd7; wdata = 64'd10;
      step();
      we = 1'b1; waddr = 5'd7; wdata = 64'd20; raddr1 = 5'd7;
      #1;
`ifdef RF_BYPASS_EN
      check("rdw_before_edge", rdata1, 64'd20);
`else
      check("rdw_before_edge", rdata1, 64'd10);
`endif
      step();
      we = 1'b0;
      #1;
      check("rdw_after_edge", rdata1, 64'd20);

      // Reset beats a concurrent write.
      we = 1'b1; waddr = 5'd3; wdata = 64'd55;
      step();
      rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 64'd9; raddr1 = 5'd3; raddr2 = 5'd3;
      #1;
      check("rst_suppresses_bypass", rdata1, 64'd55);
      step();
      rst = 1'b0; we = 1'b0; raddr2 = 5'd7;
      #1;
      check("rst_priority_x3", rdata1, 64'd0);
      check("rst_clears_x7", rdata2, 64'd0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
      for (int n = 0; n < 400; n++) begin
         rst    = ($urandom_range(0, 29) == 0);
         we     = $urandom_range(0, 1) == 1;
         waddr  = 5'($urandom_range(0, 31));
         wdata  = {$urandom, $urandom};
         raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
         aluop  = 2'($urandom_range(0, 3));
         src1   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : {$urandom, $urandom};
         src2   = ($urandom_range(0, 3) == 0) ? src1 : {$urandom, $urandom};
         #1;
         check("rand_result", result, alu_model(aluop, src1, src2));
         check("rand_rdata1", rdata1, read_model(raddr1));
         check("rand_rdata2", rdata2, read_model(raddr2));
         if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
         end else if (we && waddr != 0) begin
            model_regs[waddr] = wdata;
         end
         step();
      end

      rst = 1'b0; we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         #1;
         check($sformatf("final_rd1[%0d]", i), rdata1, (i == 0) ? 64'd0 : model_regs[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
